vga_tile_engine: RTL

// Parametrised successor to the fixed 640x480 VGA controller plus tile-map RAM pair. Generates VGA timing from fclk,

---
 rtl/vga_tile_engine.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vga_tile_engine.sv
// VGA timing generator with an on-chip tile map (req/ack write port) and external sprite-ROM pixel fetch.
// Optional feature: define SCROLL_EN to add per-frame scroll_x/scroll_y inputs.
module vga_tile_engine #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter int TILE_LOG2 = 5,
  parameter int MAP_COLS  = 20,
  parameter int MAP_ROWS  = 15,
  parameter int COL_W     = $clog2(MAP_COLS),
  parameter int ROW_W     = $clog2(MAP_ROWS),
  parameter int ID_W      = 9,
  parameter int ROM_AW    = ID_W + 2*TILE_LOG2,
  parameter int SYNC_POL  = 0
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [COL_W-1:0]  wr_x,
  input  logic [ROW_W-1:0]  wr_y,
  input  logic [ID_W-1:0]   wr_id,
  output logic              wr_ack,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [8:0]        rom_data,
`ifdef SCROLL_EN
  input  logic [COL_W+TILE_LOG2-1:0] scroll_x,
  input  logic [ROW_W+TILE_LOG2-1:0] scroll_y,
`endif
  output logic              hs,
  output logic              vs,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [2:0]        blue,
  output logic              frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W       = $clog2(H_TOTAL);
  localparam int V_W       = $clog2(V_TOTAL);
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MX_W      = COL_W + TILE_LOG2;
  localparam int MY_W      = ROW_W + TILE_LOG2;
  localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
  localparam int MA_W      = $clog2(MAP_DEPTH);
  localparam logic SYNC_ON = (SYNC_POL != 0);
  localparam bit SHARE_BY_DIV = (CLK_DIV >= 2);

  logic [DIV_W-1:0]     div;
  logic                 tick;
  logic [H_W-1:0]       h_cnt;
  logic [V_W-1:0]       v_cnt;

  logic                 h_vis, v_vis, hs_now, vs_now, frame_pt;
  logic [MX_W-1:0]      px_map;
  logic [MY_W-1:0]      py_map;
  logic [COL_W-1:0]     tile_col;
  logic [ROW_W-1:0]     tile_row;
  logic                 rd_ok;
  logic [MA_W-1:0]      rd_idx, wr_idx;
  logic                 wr_slot, grant, wr_in_map;

  logic [ID_W-1:0]      tile_map [MAP_DEPTH];
  logic [ID_W-1:0]      tile_id;
  logic [TILE_LOG2-1:0] s1_px, s1_py;
  logic                 s1_vis, s1_hs, s1_vs;
  logic                 s2_vis, s2_hs, s2_vs;

`ifdef SCROLL_EN
  localparam logic [MX_W+1:0] H_WRAP = (MX_W+2)'(MAP_COLS << TILE_LOG2);
  localparam logic [MY_W+1:0] V_WRAP = (MY_W+2)'(MAP_ROWS << TILE_LOG2);
  logic [MX_W-1:0] scroll_x_q, sx;
  logic [MY_W-1:0] scroll_y_q, sy;
  logic [MX_W+1:0] hsum;
  logic [MY_W+1:0] vsum;
`endif

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  always_comb begin
    h_vis    = h_cnt < H_W'(H_ACTIVE);
    v_vis    = v_cnt < V_W'(V_ACTIVE);
    hs_now   = (h_cnt >= H_W'(H_ACTIVE + H_FP) && h_cnt < H_W'(H_ACTIVE + H_FP + H_SYNC))
               ? SYNC_ON : ~SYNC_ON;
    vs_now   = (v_cnt >= V_W'(V_ACTIVE + V_FP) && v_cnt < V_W'(V_ACTIVE + V_FP + V_SYNC))
               ? SYNC_ON : ~SYNC_ON;
    frame_pt = (h_cnt == '0) && (v_cnt == '0);
`ifdef SCROLL_EN
    // On the frame's first tick the freshly sampled scroll must already apply to pixel (0,0).
    sx   = (tick && frame_pt) ? scroll_x : scroll_x_q;
    sy   = (tick && frame_pt) ? scroll_y : scroll_y_q;
    hsum = (MX_W+2)'(h_cnt) + (MX_W+2)'(sx);
    if (hsum >= H_WRAP) hsum = hsum - H_WRAP;
    if (hsum >= H_WRAP) hsum = hsum - H_WRAP;
    vsum = (MY_W+2)'(v_cnt) + (MY_W+2)'(sy);
    if (vsum >= V_WRAP) vsum = vsum - V_WRAP;
    if (vsum >= V_WRAP) vsum = vsum - V_WRAP;
    px_map = hsum[MX_W-1:0];
    py_map = vsum[MY_W-1:0];
`else
    px_map = MX_W'(h_cnt);
    py_map = MY_W'(v_cnt);
`endif
    tile_col  = px_map[MX_W-1:TILE_LOG2];
    tile_row  = py_map[MY_W-1:TILE_LOG2];
    rd_ok     = h_vis && v_vis && (int'(tile_col) < MAP_COLS) && (int'(tile_row) < MAP_ROWS);
    rd_idx    = rd_ok ? (MA_W'(tile_row) * MA_W'(MAP_COLS) + MA_W'(tile_col)) : '0;
    wr_in_map = (int'(wr_x) < MAP_COLS) && (int'(wr_y) < MAP_ROWS);
    wr_idx    = MA_W'(wr_y) * MA_W'(MAP_COLS) + MA_W'(wr_x);
    // Single-ported map: writes take cycles the display never reads on.
    wr_slot   = SHARE_BY_DIV ? !tick : (int'(h_cnt) >= H_ACTIVE);
    grant     = wr_req && !wr_ack && wr_slot;
  end

  always_ff @(posedge fclk) begin
    if (grant && wr_in_map) tile_map[wr_idx] <= wr_id;
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      tile_id     <= '0;
      s1_px       <= '0;
      s1_py       <= '0;
      s1_vis      <= 1'b0;
      s1_hs       <= ~SYNC_ON;
      s1_vs       <= ~SYNC_ON;
      s2_vis      <= 1'b0;
      s2_hs       <= ~SYNC_ON;
      s2_vs       <= ~SYNC_ON;
      rom_addr    <= '0;
      hs          <= ~SYNC_ON;
      vs          <= ~SYNC_ON;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
      wr_ack      <= 1'b0;
`ifdef SCROLL_EN
      scroll_x_q  <= '0;
      scroll_y_q  <= '0;
`endif
    end else begin
      wr_ack      <= grant;
      frame_start <= tick && frame_pt;
      if (tick) begin
        div <= '0;
        if (h_cnt == H_W'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_W'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
`ifdef SCROLL_EN
        if (frame_pt) begin
          scroll_x_q <= scroll_x;
          scroll_y_q <= scroll_y;
        end
`endif
        if (!grant) tile_id <= tile_map[rd_idx];
        s1_px    <= px_map[TILE_LOG2-1:0];
        s1_py    <= py_map[TILE_LOG2-1:0];
        s1_vis   <= h_vis && v_vis;
        s1_hs    <= hs_now;
        s1_vs    <= vs_now;
        rom_addr <= {tile_id, s1_py, s1_px};
        s2_vis   <= s1_vis;
        s2_hs    <= s1_hs;
        s2_vs    <= s1_vs;
        hs       <= s2_hs;
        vs       <= s2_vs;
        red      <= s2_vis ? rom_data[8:6] : '0;
        green    <= s2_vis ? rom_data[5:3] : '0;
        blue     <= s2_vis ? rom_data[2:0] : '0;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule
